mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Parametrised N-master arbiter sharing one memory port, using the CPU memory handshake: read/write strobes, byte-lane enable, addr, wdata, rdata, done.
- Sits between one or more multicycle CPU cores (and optional DMA masters) and the single data/instruction memory controller.
- Serialises requests with round-robin or fixed priority, registers the slave-side command, and returns one done pulse per transaction to the granted master.

Parameters:
- NUM_MASTERS, 2, number of master channels (1..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width (multiple of 8).
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (master 0 highest).
- TIMEOUT_CYCLES, 255, watchdog limit; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- m_read  in  NUM_MASTERS  per-master read request.
- m_write  in  NUM_MASTERS  per-master write request.
- m_dataena  in  NUM_MASTERS*DATA_W/8  per-master byte enables, packed, master 0 in LSBs.
- m_addr  in  NUM_MASTERS*ADDR_W  per-master address, packed.
- m_wdata  in  NUM_MASTERS*DATA_W  per-master write data, packed.
- m_rdata  out  DATA_W  read data, broadcast; valid only with m_done.
- m_done  out  NUM_MASTERS  one-cycle completion pulse per master.
- m_err  out  1  error flag, qualified by m_done.
- s_read  out  1  slave read strobe.
- s_write  out  1  slave write strobe.
- s_dataena  out  DATA_W/8  slave byte enables.
- s_addr  out  ADDR_W  slave address.
- s_wdata  out  DATA_W  slave write data.
- s_rdata  in  DATA_W  slave read data, valid with s_done.
- s_done  in  1  slave completion pulse.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, rr pointer=0, and all outputs 0 (s_*, m_done, m_rdata, m_err).
- Reset mid-transaction aborts immediately and no done is issued.
- Master protocol: hold read or write high, with addr/wdata/dataena stable, until its m_done pulse. Requests are level-sensitive.
- A master asserting both read and write is treated as a write.
- States:
  - IDLE: if any request, pick a winner, latch its index, addr, wdata, dataena and direction into registers; go to BUSY. s_read/s_write assert on the next cycle.
  - BUSY: hold s_* stable. On s_done, register s_rdata into m_rdata (writes: m_rdata unchanged); go to RESP.
  - RESP: m_done[winner]=1 for exactly one cycle, m_err=0; deassert s_read/s_write; return to IDLE.
- s_read/s_write are low during RESP and IDLE, so back-to-back slave accesses have a minimum 1-cycle gap.
- Latency:
  - Request sampled in IDLE at cycle 0; s_* asserted from cycle 1.
  - Slave done at cycle k gives m_done at cycle k+1.
  - Zero-wait slave (s_done in cycle 1) gives m_done at cycle 2 and the next grant sampled at cycle 3.
- Round-robin: search starts at index (last winner + 1) mod NUM_MASTERS; rr pointer updates in RESP.
- Fixed priority: lowest index wins.
- The master's own requests are ignored in RESP, so it cannot be regranted before it sees done.
- A master dropping its request while granted is a protocol violation: the transaction still completes and done is still pulsed.
- s_done outside BUSY is ignored.
- NUM_MASTERS=1 degenerates to a registered pass-through with the same latency.
- Multiple-grant is impossible: m_done is one-hot or zero in every cycle.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYCLES without s_done: drop s_read/s_write, go to RESP, pulse m_done[winner] with m_err=1 and m_rdata = all-ones.
  - An s_done arriving in the same cycle as the timeout wins: normal completion, m_err=0.
- Undefined: no counter logic; m_err is tied 0; BUSY waits for s_done indefinitely.

Test Plan:
- Single read: m0 read, addr=0x100, slave returns 0x12345678 with done 3 cycles after s_read -> s_read high cycles 1..3, m_done[0] at cycle 4, m_rdata=0x12345678, m_err=0.
- Round-robin contention (ARB_MODE=0): m0 and m1 both hold write continuously, 0-wait slave -> grants alternate m0,m1,m0,m1; s_addr/s_wdata match the granted master each time; never two m_done bits set.
- Fixed priority (ARB_MODE=1): m0 and m1 requesting, m0 re-requests immediately after each done -> m0 always served; m1 granted only once m0 is idle.
- Byte write: m1 write, dataena=4'b0100, wdata=0xAABBCCDD -> s_dataena=4'b0100, s_wdata=0xAABBCCDD, s_write held until s_done; read+write both high -> s_write only.
- Reset mid-BUSY: assert rst=0 while s_read=1 -> all outputs 0 immediately and no m_done; after release, the pending request is granted starting from m0.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): slave never responds -> s_read drops after 8 BUSY cycles, m_done pulses with m_err=1 and m_rdata=0xFFFFFFFF; second run with s_done on the 8th cycle -> m_err=0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: N-master arbiter sharing one memory port using the CPU
// read/write/dataena/addr/wdata/rdata/done handshake. Requests are latched
// in IDLE, presented to the slave from registers in BUSY, and answered with
// a one-cycle done pulse to the winner in RESP.
// Optional build macro: ARB_TIMEOUT_EN adds a BUSY watchdog that completes
// a hung access with m_err=1 and all-ones read data.
module mem_bus_arbiter #(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ARB_MODE       = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_MASTERS-1:0]          m_read,
    input  logic [NUM_MASTERS-1:0]          m_write,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] m_dataena,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata,
    output logic [DATA_W-1:0]               m_rdata,
    output logic [NUM_MASTERS-1:0]          m_done,
    output logic                            m_err,
    output logic                            s_read,
    output logic                            s_write,
    output logic [DATA_W/8-1:0]             s_dataena,
    output logic [ADDR_W-1:0]               s_addr,
    output logic [DATA_W-1:0]               s_wdata,
    input  logic [DATA_W-1:0]               s_rdata,
    input  logic                            s_done
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic              is_write;
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       win_q, win_d;
    logic [IDX_W-1:0]       rr_q, rr_d;
    cmd_t                   cmd_q, cmd_d;
    logic                   s_read_q, s_read_d;
    logic                   s_write_q, s_write_d;
    logic [DATA_W-1:0]      m_rdata_q, m_rdata_d;
    logic [NUM_MASTERS-1:0] m_done_q, m_done_d;
    logic                   m_err_q, m_err_d;

    logic [NUM_MASTERS-1:0] req_c;
    logic                   any_req_c;
    logic [IDX_W-1:0]       pick_c;
    cmd_t                   pick_cmd_c;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_c;
    assign tmo_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic tmo_cfg_unused;
    assign tmo_cfg_unused = (TIMEOUT_CYCLES != 0);
`endif

    // A simultaneous read+write request counts as a write.
    assign req_c     = m_read | m_write;
    assign any_req_c = |req_c;

    // Winner search: from rr pointer (round-robin) or from index 0 (fixed).
    always_comb begin
        logic        found;
        int unsigned idx;
        found  = 1'b0;
        idx    = 0;
        pick_c = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            idx = (ARB_MODE == 1) ? i : ((32'(rr_q) + i) % NUM_MASTERS);
            if (!found && req_c[IDX_W'(idx)]) begin
                found  = 1'b1;
                pick_c = IDX_W'(idx);
            end
        end
    end

    // Extract the winning master's command fields from the packed buses.
    always_comb begin
        int unsigned sel;
        sel                 = 32'(pick_c);
        pick_cmd_c.is_write = m_write[pick_c];
        pick_cmd_c.be       = m_dataena[sel*BE_W +: BE_W];
        pick_cmd_c.addr     = m_addr[sel*ADDR_W +: ADDR_W];
        pick_cmd_c.wdata    = m_wdata[sel*DATA_W +: DATA_W];
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        rr_d      = rr_q;
        cmd_d     = cmd_q;
        s_read_d  = s_read_q;
        s_write_d = s_write_q;
        m_rdata_d = m_rdata_q;
        m_done_d  = '0;
        m_err_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                s_read_d  = 1'b0;
                s_write_d = 1'b0;
                if (any_req_c) begin
                    win_d     = pick_c;
                    cmd_d     = pick_cmd_c;
                    s_read_d  = !pick_cmd_c.is_write;
                    s_write_d = pick_cmd_c.is_write;
                    state_d   = BUSY;
`ifdef ARB_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            BUSY: begin
                if (s_done) begin
                    if (!cmd_q.is_write) begin
                        m_rdata_d = s_rdata;
                    end
                    m_done_d  = NUM_MASTERS'(1) << win_q;
                    s_read_d  = 1'b0;
                    s_write_d = 1'b0;
                    state_d   = RESP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_c) begin
                    m_rdata_d = '1;
                    m_err_d   = 1'b1;
                    m_done_d  = NUM_MASTERS'(1) << win_q;
                    s_read_d  = 1'b0;
                    s_write_d = 1'b0;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                s_read_d  = 1'b0;
                s_write_d = 1'b0;
                rr_d      = (32'(win_q) == NUM_MASTERS - 1) ? '0 : (win_q + 1'b1);
                state_d   = IDLE;
            end
            default: begin
                s_read_d  = 1'b0;
                s_write_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            win_q     <= '0;
            rr_q      <= '0;
            cmd_q     <= '0;
            s_read_q  <= 1'b0;
            s_write_q <= 1'b0;
            m_rdata_q <= '0;
            m_done_q  <= '0;
            m_err_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            rr_q      <= rr_d;
            cmd_q     <= cmd_d;
            s_read_q  <= s_read_d;
            s_write_q <= s_write_d;
            m_rdata_q <= m_rdata_d;
            m_done_q  <= m_done_d;
            m_err_q   <= m_err_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign s_read    = s_read_q;
    assign s_write   = s_write_q;
    assign s_dataena = cmd_q.be;
    assign s_addr    = cmd_q.addr;
    assign s_wdata   = cmd_q.wdata;
    assign m_rdata   = m_rdata_q;
    assign m_done    = m_done_q;
    assign m_err     = m_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter: a round-robin and a fixed-priority
// instance share the master inputs; each has its own slave done strobe.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  m_read;
    logic [1:0]  m_write;
    logic [7:0]  m_dataena;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [31:0] s_rdata;
    logic        s_done_rr;
    logic        s_done_fp;

    logic [31:0] rr_m_rdata, fp_m_rdata;
    logic [1:0]  rr_m_done, fp_m_done;
    logic        rr_m_err, fp_m_err;
    logic        rr_s_read, fp_s_read;
    logic        rr_s_write, fp_s_write;
    logic [3:0]  rr_s_dataena, fp_s_dataena;
    logic [31:0] rr_s_addr, fp_s_addr;
    logic [31:0] rr_s_wdata, fp_s_wdata;

    int errors = 0;
    int checks = 0;

    mem_bus_arbiter #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0), .TIMEOUT_CYCLES(8)) u_rr (
        .clk(clk), .rst(rst), .m_read(m_read), .m_write(m_write), .m_dataena(m_dataena),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(rr_m_rdata), .m_done(rr_m_done), .m_err(rr_m_err),
        .s_read(rr_s_read), .s_write(rr_s_write), .s_dataena(rr_s_dataena), .s_addr(rr_s_addr),
        .s_wdata(rr_s_wdata), .s_rdata(s_rdata), .s_done(s_done_rr)
    );

    mem_bus_arbiter #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1), .TIMEOUT_CYCLES(8)) u_fp (
        .clk(clk), .rst(rst), .m_read(m_read), .m_write(m_write), .m_dataena(m_dataena),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(fp_m_rdata), .m_done(fp_m_done), .m_err(fp_m_err),
        .s_read(fp_s_read), .s_write(fp_s_write), .s_dataena(fp_s_dataena), .s_addr(fp_s_addr),
        .s_wdata(fp_s_wdata), .s_rdata(s_rdata), .s_done(s_done_fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst       = 1'b0;
        m_read    = '0;
        m_write   = '0;
        s_done_rr = 1'b0;
        s_done_fp = 1'b0;
        tick;
        tick;
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick;
        tick;
        checks++; if (rr_s_read !== 1'b0 || rr_s_write !== 1'b0) begin errors++; $display("FAIL reset_rr_strobes got r=%b w=%b exp 0 0", rr_s_read, rr_s_write); end
        checks++; if (rr_m_done !== 2'b00 || rr_m_err !== 1'b0) begin errors++; $display("FAIL reset_rr_done got done=%b err=%b exp 00 0", rr_m_done, rr_m_err); end
        checks++; if (rr_m_rdata !== 32'h0 || rr_s_addr !== 32'h0) begin errors++; $display("FAIL reset_rr_data got rdata=%h addr=%h exp 0 0", rr_m_rdata, rr_s_addr); end
        checks++; if (fp_s_read !== 1'b0 || fp_s_write !== 1'b0 || fp_m_done !== 2'b00) begin errors++; $display("FAIL reset_fp_outputs got r=%b w=%b done=%b exp 0 0 00", fp_s_read, fp_s_write, fp_m_done); end
        rst = 1'b1;
        tick;
        checks++; if (rr_s_read !== 1'b0 || rr_s_write !== 1'b0) begin errors++; $display("FAIL reset_idle_no_req got r=%b w=%b exp 0 0", rr_s_read, rr_s_write); end
    endtask

    task automatic test_single_read;
        m_addr[31:0] = 32'h100;
        m_read       = 2'b01;
        checks++; if (rr_s_read !== 1'b0) begin errors++; $display("FAIL single_read_c0 s_read got %b exp 0", rr_s_read); end
        for (int c = 1; c <= 3; c++) begin
            tick;
            checks++; if (rr_s_read !== 1'b1 || rr_s_addr !== 32'h100) begin errors++; $display("FAIL single_read_c%0d got s_read=%b addr=%h exp 1 100", c, rr_s_read, rr_s_addr); end
            if (c == 3) begin
                s_rdata   = 32'h12345678;
                s_done_rr = 1'b1;
            end
        end
        tick;
        s_done_rr = 1'b0;
        m_read    = 2'b00;
        checks++; if (rr_m_done !== 2'b01) begin errors++; $display("FAIL single_read_done got %b exp 01", rr_m_done); end
        checks++; if (rr_m_rdata !== 32'h12345678 || rr_m_err !== 1'b0) begin errors++; $display("FAIL single_read_data got rdata=%h err=%b exp 12345678 0", rr_m_rdata, rr_m_err); end
        checks++; if (rr_s_read !== 1'b0) begin errors++; $display("FAIL single_read_resp_strobe got %b exp 0", rr_s_read); end
        tick;
        checks++; if (rr_m_done !== 2'b00) begin errors++; $display("FAIL single_read_done_width got %b exp 00", rr_m_done); end
    endtask

    task automatic test_rr_contention;
        logic [31:0] ea, ed;
        logic [1:0]  edone;
        apply_reset;
        m_addr    = {32'h20, 32'h10};
        m_wdata   = {32'hB1, 32'hA0};
        m_dataena = 8'hFF;
        m_write   = 2'b11;
        for (int k = 0; k < 4; k++) begin
            ea    = (k % 2 == 1) ? 32'h20 : 32'h10;
            ed    = (k % 2 == 1) ? 32'hB1 : 32'hA0;
            edone = (k % 2 == 1) ? 2'b10 : 2'b01;
            tick;
            checks++; if (rr_s_write !== 1'b1 || rr_s_read !== 1'b0) begin errors++; $display("FAIL rr_grant%0d strobes got w=%b r=%b exp 1 0", k, rr_s_write, rr_s_read); end
            checks++; if (rr_s_addr !== ea || rr_s_wdata !== ed) begin errors++; $display("FAIL rr_grant%0d cmd got addr=%h wdata=%h exp %h %h", k, rr_s_addr, rr_s_wdata, ea, ed); end
            s_done_rr = 1'b1;
            tick;
            s_done_rr = 1'b0;
            checks++; if (rr_m_done !== edone || rr_s_write !== 1'b0) begin errors++; $display("FAIL rr_done%0d got done=%b w=%b exp %b 0", k, rr_m_done, rr_s_write, edone); end
            tick;
            checks++; if (rr_m_done !== 2'b00) begin errors++; $display("FAIL rr_gap%0d done got %b exp 00", k, rr_m_done); end
        end
        m_write = 2'b00;
        tick;
        checks++; if (rr_s_write !== 1'b0) begin errors++; $display("FAIL rr_idle_after got w=%b exp 0", rr_s_write); end
    endtask

    task automatic test_fixed_priority;
        apply_reset;
        m_addr  = {32'h200, 32'h100};
        m_write = 2'b01;
        m_read  = 2'b10;
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++; if (fp_s_write !== 1'b1 || fp_s_addr !== 32'h100) begin errors++; $display("FAIL fp_m0_grant%0d got w=%b addr=%h exp 1 100", k, fp_s_write, fp_s_addr); end
            s_done_fp = 1'b1;
            tick;
            s_done_fp = 1'b0;
            checks++; if (fp_m_done !== 2'b01) begin errors++; $display("FAIL fp_m0_done%0d got %b exp 01", k, fp_m_done); end
            if (k == 2) m_write = 2'b00;
            tick;
        end
        tick;
        checks++; if (fp_s_read !== 1'b1 || fp_s_write !== 1'b0 || fp_s_addr !== 32'h200) begin errors++; $display("FAIL fp_m1_grant got r=%b w=%b addr=%h exp 1 0 200", fp_s_read, fp_s_write, fp_s_addr); end
        s_rdata   = 32'hCAFEF00D;
        s_done_fp = 1'b1;
        tick;
        s_done_fp = 1'b0;
        m_read    = 2'b00;
        checks++; if (fp_m_done !== 2'b10 || fp_m_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL fp_m1_done got done=%b rdata=%h exp 10 cafef00d", fp_m_done, fp_m_rdata); end
        tick;
    endtask

    task automatic test_byte_write;
        apply_reset;
        m_addr[63:32]  = 32'h240;
        m_wdata[63:32] = 32'hAABBCCDD;
        m_dataena      = 8'b0100_0000;
        m_write        = 2'b10;
        m_read         = 2'b10;
        for (int c = 1; c <= 3; c++) begin
            tick;
            checks++; if (rr_s_write !== 1'b1 || rr_s_read !== 1'b0) begin errors++; $display("FAIL bw_strobe_c%0d got w=%b r=%b exp 1 0", c, rr_s_write, rr_s_read); end
            checks++; if (rr_s_dataena !== 4'b0100 || rr_s_wdata !== 32'hAABBCCDD || rr_s_addr !== 32'h240) begin errors++; $display("FAIL bw_cmd_c%0d got be=%b wdata=%h addr=%h exp 0100 aabbccdd 240", c, rr_s_dataena, rr_s_wdata, rr_s_addr); end
        end
        s_rdata   = 32'hDEADBEEF;
        s_done_rr = 1'b1;
        tick;
        s_done_rr = 1'b0;
        m_write   = 2'b00;
        m_read    = 2'b00;
        checks++; if (rr_m_done !== 2'b10 || rr_s_write !== 1'b0) begin errors++; $display("FAIL bw_done got done=%b w=%b exp 10 0", rr_m_done, rr_s_write); end
        checks++; if (rr_m_rdata !== 32'h0) begin errors++; $display("FAIL bw_rdata_held got %h exp 00000000", rr_m_rdata); end
        tick;
    endtask

    task automatic test_reset_mid_busy;
        apply_reset;
        m_addr    = {32'h200, 32'h100};
        m_dataena = 8'hFF;
        m_read    = 2'b01;
        tick;
        s_done_rr = 1'b1;
        tick;
        s_done_rr = 1'b0;
        m_read    = 2'b11;
        tick;
        tick;
        checks++; if (rr_s_read !== 1'b1 || rr_s_addr !== 32'h200) begin errors++; $display("FAIL rmb_pre_grant got r=%b addr=%h exp 1 200", rr_s_read, rr_s_addr); end
        rst = 1'b0;
        #1;
        checks++; if (rr_s_read !== 1'b0 || rr_s_write !== 1'b0 || rr_m_done !== 2'b00) begin errors++; $display("FAIL rmb_async_strobes got r=%b w=%b done=%b exp 0 0 00", rr_s_read, rr_s_write, rr_m_done); end
        checks++; if (rr_s_addr !== 32'h0 || rr_s_dataena !== 4'h0 || rr_m_rdata !== 32'h0 || rr_m_err !== 1'b0) begin errors++; $display("FAIL rmb_async_data got addr=%h be=%h rdata=%h err=%b exp 0 0 0 0", rr_s_addr, rr_s_dataena, rr_m_rdata, rr_m_err); end
        tick;
        tick;
        checks++; if (rr_m_done !== 2'b00 || rr_s_read !== 1'b0) begin errors++; $display("FAIL rmb_held got done=%b r=%b exp 00 0", rr_m_done, rr_s_read); end
        rst = 1'b1;
        tick;
        checks++; if (rr_s_read !== 1'b1 || rr_s_addr !== 32'h100) begin errors++; $display("FAIL rmb_regrant got r=%b addr=%h exp 1 100", rr_s_read, rr_s_addr); end
        s_rdata   = 32'h11;
        s_done_rr = 1'b1;
        tick;
        s_done_rr = 1'b0;
        m_read    = 2'b00;
        checks++; if (rr_m_done !== 2'b01) begin errors++; $display("FAIL rmb_done got %b exp 01", rr_m_done); end
        tick;
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout;
        apply_reset;
        m_addr[31:0] = 32'h100;
        m_read       = 2'b01;
        for (int c = 1; c <= 8; c++) begin
            tick;
            checks++; if (rr_s_read !== 1'b1) begin errors++; $display("FAIL tmo_busy_c%0d s_read got %b exp 1", c, rr_s_read); end
        end
        tick;
        m_read = 2'b00;
        checks++; if (rr_s_read !== 1'b0 || rr_m_done !== 2'b01) begin errors++; $display("FAIL tmo_fire got r=%b done=%b exp 0 01", rr_s_read, rr_m_done); end
        checks++; if (rr_m_err !== 1'b1 || rr_m_rdata !== 32'hFFFFFFFF) begin errors++; $display("FAIL tmo_err got err=%b rdata=%h exp 1 ffffffff", rr_m_err, rr_m_rdata); end
        tick;
        checks++; if (rr_m_done !== 2'b00 || rr_m_err !== 1'b0) begin errors++; $display("FAIL tmo_after got done=%b err=%b exp 00 0", rr_m_done, rr_m_err); end
        m_read = 2'b01;
        for (int c = 1; c <= 8; c++) begin
            tick;
            checks++; if (rr_s_read !== 1'b1) begin errors++; $display("FAIL tmo2_busy_c%0d s_read got %b exp 1", c, rr_s_read); end
            if (c == 8) begin
                s_rdata   = 32'h5A5A5A5A;
                s_done_rr = 1'b1;
            end
        end
        tick;
        s_done_rr = 1'b0;
        m_read    = 2'b00;
        checks++; if (rr_m_done !== 2'b01 || rr_m_err !== 1'b0 || rr_m_rdata !== 32'h5A5A5A5A) begin errors++; $display("FAIL tmo_race got done=%b err=%b rdata=%h exp 01 0 5a5a5a5a", rr_m_done, rr_m_err, rr_m_rdata); end
        tick;
    endtask
`else
    task automatic test_no_timeout;
        apply_reset;
        m_addr[31:0] = 32'h100;
        m_read       = 2'b01;
        repeat (40) tick;
        checks++; if (rr_s_read !== 1'b1 || rr_m_done !== 2'b00 || rr_m_err !== 1'b0) begin errors++; $display("FAIL notmo_wait got r=%b done=%b err=%b exp 1 00 0", rr_s_read, rr_m_done, rr_m_err); end
        s_rdata   = 32'h0BADF00D;
        s_done_rr = 1'b1;
        tick;
        s_done_rr = 1'b0;
        m_read    = 2'b00;
        checks++; if (rr_m_done !== 2'b01 || rr_m_err !== 1'b0 || rr_m_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL notmo_done got done=%b err=%b rdata=%h exp 01 0 0badf00d", rr_m_done, rr_m_err, rr_m_rdata); end
        tick;
    endtask
`endif

    initial begin
        rst       = 1'b0;
        m_read    = '0;
        m_write   = '0;
        m_dataena = 8'hFF;
        m_addr    = '0;
        m_wdata   = '0;
        s_rdata   = '0;
        s_done_rr = 1'b0;
        s_done_fp = 1'b0;
        test_reset;
        test_single_read;
        test_rr_contention;
        test_fixed_priority;
        test_byte_write;
        test_reset_mid_busy;
`ifdef ARB_TIMEOUT_EN
        test_timeout;
`else
        test_no_timeout;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
